// File: rtl/uart_rx_buffered_pkg.sv
// Shared UART frame constants and receiver FSM state encoding.
// The host transmitter uses the same definitions.
package uart_rx_buffered_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Ready/valid byte stream from the UART receiver to the CPU-side consumer.
interface uart_rx_buffered_if;
    import uart_rx_buffered_pkg::*;

    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );

endinterface

// File: rtl/uart_rx_buffered_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_buffered_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, stop-bit check,
// and a FWFT byte FIFO read through a ready/valid interface.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 10_000_000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    uart_rx_buffered_if.master  out_if,
    output logic                framing_error,
    output logic                overrun,
    input  logic                status_clear
);

    localparam int unsigned CYC   = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF  = CYC / 2;
    localparam int unsigned CNT_W = $clog2(CYC);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    uart_state_e          state_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shreg_q;

    logic                 bit_end;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign bit_end = (clk_cnt_q == CNT_W'(CYC - 1));
    assign push    = (state_q == StStop) && bit_end && rx_s_q;
    assign pop     = out_if.data_out_valid && out_if.data_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    clk_cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    // Re-check the start bit at its middle to reject glitches.
                    if (clk_cnt_q == CNT_W'(HALF - 1)) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s_q ? StIdle : StData;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shreg_q[bit_idx_q] <= rx_s_q;
                        clk_cnt_q          <= '0;
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (bit_end) begin
                        framing_error <= !rx_s_q;
                        clk_cnt_q     <= '0;
                        state_q       <= StIdle;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun <= 1'b1;
        end else if (status_clear) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_buffered_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg_q),
        .pop       (pop),
        .rd_data   (out_if.data_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.data_out_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at 50 MHz / 10 Mbaud (5 clocks per bit).
module tb_uart_rx_buffered;
    import uart_rx_buffered_pkg::*;

    localparam int unsigned CYC = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic framing_error;
    logic overrun;
    logic status_clear = 1'b0;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int rise_cnt = 0;
    int snap;
    logic valid_prev = 1'b0;

    uart_rx_buffered_if dbus ();

    uart_rx_buffered #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (10_000_000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .out_if        (dbus.master),
        .framing_error (framing_error),
        .overrun       (overrun),
        .status_clear  (status_clear)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (dbus.data_out_valid && !valid_prev) rise_cnt <= rise_cnt + 1;
        valid_prev <= dbus.data_out_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        wait_cycles(CYC);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            wait_cycles(CYC);
        end
        serial_in = stop;
        wait_cycles(CYC);
        serial_in = 1'b1;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !dbus.data_out_valid; i++) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(dbus.data_out_valid), 32'd1);
        check({tag, "_data"}, 32'(dbus.data_out), 32'(exp));
        dbus.data_out_ready = 1'b1;
        @(negedge clk);
        dbus.data_out_ready = 1'b0;
    endtask

    initial begin
        dbus.data_out_ready = 1'b0;
        wait_cycles(4);
        check("reset_valid", 32'(dbus.data_out_valid), 32'd0);
        check("reset_fe", 32'(framing_error), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        wait_cycles(10);

        // 1: single byte held until popped
        snap = rise_cnt;
        send_byte(8'h61, 1'b1);
        wait_valid(20);
        check("t1_valid", 32'(dbus.data_out_valid), 32'd1);
        check("t1_data", 32'(dbus.data_out), 32'h61);
        wait_cycles(15);
        check("t1_hold_valid", 32'(dbus.data_out_valid), 32'd1);
        check("t1_hold_data", 32'(dbus.data_out), 32'h61);
        check("t1_one_rise", 32'(rise_cnt - snap), 32'd1);
        pop_check("t1_pop", 8'h61);
        check("t1_empty", 32'(dbus.data_out_valid), 32'd0);

        // 2: back-to-back frames, zero idle
        snap = fe_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        wait_cycles(15);
        pop_check("t2_first", 8'h55);
        pop_check("t2_second", 8'hAA);
        check("t2_empty", 32'(dbus.data_out_valid), 32'd0);
        check("t2_no_fe", 32'(fe_cnt - snap), 32'd0);
        check("t2_no_overrun", 32'(overrun), 32'd0);

        // 3: one-cycle glitch rejected
        serial_in = 1'b0;
        @(negedge clk);
        serial_in = 1'b1;
        wait_cycles(15);
        check("t3_no_byte", 32'(dbus.data_out_valid), 32'd0);
        check("t3_idle", 32'(dut.state_q), 32'(StIdle));
        send_byte(8'h3e, 1'b1);
        wait_valid(20);
        pop_check("t3_after", 8'h3e);

        // 4: framing error
        snap = fe_cnt;
        send_byte(8'h3e, 1'b0);
        wait_cycles(25);
        check("t4_fe_pulse", 32'(fe_cnt - snap), 32'd1);
        check("t4_fe_low", 32'(framing_error), 32'd0);
        check("t4_no_byte", 32'(dbus.data_out_valid), 32'd0);

        // 5: overrun with 9 bytes into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
        wait_cycles(15);
        check("t5_overrun", 32'(overrun), 32'd1);
        for (int i = 1; i <= 8; i++) pop_check("t5_pop", 8'(i));
        check("t5_empty", 32'(dbus.data_out_valid), 32'd0);
        check("t5_sticky", 32'(overrun), 32'd1);
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
        check("t5_cleared", 32'(overrun), 32'd0);

        // 6: reset mid-frame flushes FIFO and partial byte
        send_byte(8'h61, 1'b1);
        wait_valid(20);
        check("t6_prefill", 32'(dbus.data_out_valid), 32'd1);
        serial_in = 1'b0;
        wait_cycles(CYC);
        for (int i = 0; i < 4; i++) begin
            serial_in = i[0] ? 1'b0 : 1'b1;
            wait_cycles(CYC);
        end
        serial_in = 1'b0;
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(2);
        serial_in = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_flushed", 32'(dbus.data_out_valid), 32'd0);
        check("t6_idle", 32'(dut.state_q), 32'(StIdle));
        wait_cycles(20);
        check("t6_no_byte", 32'(dbus.data_out_valid), 32'd0);
        send_byte(8'h0d, 1'b1);
        wait_valid(20);
        pop_check("t6_after", 8'h0d);
        check("t6_end_empty", 32'(dbus.data_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
